// File: rtl/ir_drive_pkg.sv
// Shared state encodings, key bit positions and helpers for the IR drive controller.
package ir_drive_pkg;

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        FWD    = 3'd1,
        REV    = 3'd2,
        TURN_L = 3'd3,
        TURN_R = 3'd4,
        BRAKE  = 3'd5
    } drv_state_t;

    localparam int KEY_0     = 16;
    localparam int KEY_1     = 15;
    localparam int KEY_2     = 14;
    localparam int KEY_3     = 13;
    localparam int KEY_4     = 12;
    localparam int KEY_5     = 11;
    localparam int KEY_6     = 10;
    localparam int KEY_7     = 9;
    localparam int KEY_8     = 8;
    localparam int KEY_9     = 7;
    localparam int KEY_OK    = 6;
    localparam int KEY_UP    = 5;
    localparam int KEY_DOWN  = 4;
    localparam int KEY_LEFT  = 3;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_STAR  = 1;
    localparam int KEY_HASH  = 0;

    localparam logic [3:0] MAX_LVL = 4'd9;

    function automatic logic is_motion(drv_state_t s);
        return s inside {FWD, REV, TURN_L, TURN_R};
    endfunction

    // {left, right}, 1 = forward
    function automatic logic [1:0] motor_dirs(drv_state_t s);
        logic [1:0] d;
        case (s)
            FWD:     d = 2'b11;
            TURN_L:  d = 2'b01;
            TURN_R:  d = 2'b10;
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    // {valid, digit}; expects a word with at most one bit set
    function automatic logic [4:0] key_digit(logic [16:0] k);
        logic [4:0] r;
        r = 5'd0;
        unique case (1'b1)
            k[KEY_0]: r = {1'b1, 4'd0};
            k[KEY_1]: r = {1'b1, 4'd1};
            k[KEY_2]: r = {1'b1, 4'd2};
            k[KEY_3]: r = {1'b1, 4'd3};
            k[KEY_4]: r = {1'b1, 4'd4};
            k[KEY_5]: r = {1'b1, 4'd5};
            k[KEY_6]: r = {1'b1, 4'd6};
            k[KEY_7]: r = {1'b1, 4'd7};
            k[KEY_8]: r = {1'b1, 4'd8};
            k[KEY_9]: r = {1'b1, 4'd9};
            default:  r = 5'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ir_drive_ctrl_pwm.sv
// Free-running PWM period counter with duty compare against the applied level.
module ir_pwm_gen #(
    parameter int PWM_PERIOD = 1000,
    parameter int PWM_STEP   = 100
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic [3:0] i_eff_lvl,
    output logic       o_pwm_on
);

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (int'(r_cnt) == PWM_PERIOD - 1) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_pwm_on = int'(r_cnt) < int'(i_eff_lvl) * PWM_STEP;

endmodule

// File: rtl/ir_drive_ctrl.sv
// IR key events to drive states with brake dead-time, hold timeout and PWM enables.
// Optional ramped speed on motion entry: define SOFT_START_EN.
module ir_drive_ctrl
    import ir_drive_pkg::*;
#(
    parameter int HOLD_CYC   = 200000,
    parameter int DEAD_CYC   = 20000,
    parameter int PWM_PERIOD = 1000,
    parameter int PWM_STEP   = 100,
    parameter int SPEED_INIT = 5
`ifdef SOFT_START_EN
    ,
    parameter int RAMP_CYC   = 50000
`endif
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [16:0] key_onehot,
    output logic        mot_l_en,
    output logic        mot_l_dir,
    output logic        mot_r_en,
    output logic        mot_r_dir,
    output logic [3:0]  speed_lvl,
    output logic [3:0]  eff_lvl,
    output logic [2:0]  drv_state
);

    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic [16:0]   r_key_prev;
    logic          w_evt;
    logic [16:0]   w_key;
    logic          w_mkey;
    drv_state_t    w_tgt;
    logic [4:0]    w_digit;
    drv_state_t    r_state;
    drv_state_t    w_state_nx;
    drv_state_t    r_pend;
    drv_state_t    w_pend_nx;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nx;
    logic [DW-1:0] r_dead;
    logic [DW-1:0] w_dead_nx;
    logic [3:0]    r_speed;
    logic [3:0]    w_eff;
    logic          w_pwm_on;

    // A held or chorded key produces no event
    assign w_evt = (key_onehot != '0)
                && ((key_onehot & (key_onehot - 17'd1)) == '0)
                && (r_key_prev == '0);
    assign w_key   = w_evt ? key_onehot : '0;
    assign w_digit = key_digit(w_key);

    always_comb begin
        w_mkey = 1'b1;
        w_tgt  = STOP;
        unique case (1'b1)
            w_key[KEY_UP]:    w_tgt = FWD;
            w_key[KEY_DOWN]:  w_tgt = REV;
            w_key[KEY_LEFT]:  w_tgt = TURN_L;
            w_key[KEY_RIGHT]: w_tgt = TURN_R;
            default:          w_mkey = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_pend_nx  = r_pend;
        w_hold_nx  = r_hold;
        w_dead_nx  = r_dead;
        if (w_key[KEY_OK]) begin
            w_state_nx = STOP;
            w_pend_nx  = STOP;
            w_hold_nx  = '0;
            w_dead_nx  = '0;
        end else begin
            case (r_state)
                STOP: begin
                    if (w_mkey) begin
                        w_state_nx = w_tgt;
                        w_hold_nx  = HW'(HOLD_CYC);
                    end
                end
                BRAKE: begin
                    if (w_mkey) w_pend_nx = w_tgt;
                    if (r_dead > DW'(1)) begin
                        w_dead_nx = r_dead - DW'(1);
                    end else begin
                        w_state_nx = w_mkey ? w_tgt : r_pend;
                        w_pend_nx  = STOP;
                        w_hold_nx  = HW'(HOLD_CYC);
                        w_dead_nx  = '0;
                    end
                end
                default: begin
                    // A key in the expiry cycle takes priority over the timeout
                    if (w_mkey && w_tgt == r_state) begin
                        w_hold_nx = HW'(HOLD_CYC);
                    end else if (w_mkey) begin
                        w_state_nx = BRAKE;
                        w_pend_nx  = w_tgt;
                        w_dead_nx  = DW'(DEAD_CYC);
                        w_hold_nx  = '0;
                    end else if (r_hold > HW'(1)) begin
                        w_hold_nx = r_hold - HW'(1);
                    end else begin
                        w_state_nx = STOP;
                        w_hold_nx  = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_key_prev <= '0;
            r_state    <= STOP;
            r_pend     <= STOP;
            r_hold     <= '0;
            r_dead     <= '0;
        end else begin
            r_key_prev <= key_onehot;
            r_state    <= w_state_nx;
            r_pend     <= w_pend_nx;
            r_hold     <= w_hold_nx;
            r_dead     <= w_dead_nx;
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_speed <= 4'(SPEED_INIT);
        end else if (w_digit[4]) begin
            r_speed <= w_digit[3:0];
        end else if (w_key[KEY_STAR] && r_speed != 4'd0) begin
            r_speed <= r_speed - 4'd1;
        end else if (w_key[KEY_HASH] && r_speed < MAX_LVL) begin
            r_speed <= r_speed + 4'd1;
        end
    end

`ifdef SOFT_START_EN
    localparam int RW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

    logic [3:0]    r_ramp;
    logic [RW-1:0] r_ramp_cnt;

    always_ff @(posedge clk_d) begin
        if (rst || !is_motion(w_state_nx)) begin
            r_ramp     <= '0;
            r_ramp_cnt <= '0;
        end else if (!is_motion(r_state)) begin
            r_ramp     <= (r_speed != 4'd0) ? 4'd1 : 4'd0;
            r_ramp_cnt <= '0;
        end else if (r_speed < r_ramp) begin
            r_ramp <= r_speed;
        end else if (int'(r_ramp_cnt) >= RAMP_CYC - 1) begin
            r_ramp_cnt <= '0;
            if (r_ramp < r_speed) r_ramp <= r_ramp + 4'd1;
        end else begin
            r_ramp_cnt <= r_ramp_cnt + RW'(1);
        end
    end

    always_comb begin
        w_eff = '0;
        if (is_motion(r_state)) w_eff = (r_speed < r_ramp) ? r_speed : r_ramp;
    end
`else
    always_comb begin
        w_eff = '0;
        if (is_motion(r_state)) w_eff = r_speed;
    end
`endif

    ir_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_STEP   (PWM_STEP)
    ) u_pwm (
        .clk_d     (clk_d),
        .rst       (rst),
        .i_eff_lvl (w_eff),
        .o_pwm_on  (w_pwm_on)
    );

    always_ff @(posedge clk_d) begin
        if (rst) begin
            drv_state <= STOP;
            speed_lvl <= 4'(SPEED_INIT);
            eff_lvl   <= '0;
            mot_l_en  <= 1'b0;
            mot_r_en  <= 1'b0;
            mot_l_dir <= 1'b0;
            mot_r_dir <= 1'b0;
        end else begin
            drv_state <= r_state;
            speed_lvl <= r_speed;
            eff_lvl   <= w_eff;
            mot_l_en  <= is_motion(r_state) && w_pwm_on;
            mot_r_en  <= is_motion(r_state) && w_pwm_on;
            {mot_l_dir, mot_r_dir} <= motor_dirs(r_state);
        end
    end

endmodule

// File: tb/tb_ir_drive_ctrl.sv
// Bench for ir_drive_ctrl: vector table, directed corner sequences and
// random keys against a deadline-based reference model.
module tb_ir_drive_ctrl;

    localparam int HOLD  = 100;
    localparam int DEAD  = 10;
    localparam int PER   = 10;
    localparam int STEP  = 1;
    localparam int SINIT = 5;

    localparam logic [16:0] K_UP   = 17'h00020;
    localparam logic [16:0] K_DOWN = 17'h00010;
    localparam logic [16:0] K_LEFT = 17'h00008;
    localparam logic [16:0] K_OK   = 17'h00040;
    localparam logic [16:0] K_STAR = 17'h00002;
    localparam logic [16:0] K_HASH = 17'h00001;
    localparam logic [16:0] K_0    = 17'h10000;
    localparam logic [16:0] K_1    = 17'h08000;
    localparam logic [16:0] K_7    = 17'h00200;
    localparam logic [16:0] K_9    = 17'h00080;

    logic        clk_d = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] key_onehot = '0;
    logic        mot_l_en, mot_l_dir, mot_r_en, mot_r_dir;
    logic [3:0]  speed_lvl, eff_lvl;
    logic [2:0]  drv_state;

    int checks = 0;
    int failures = 0;
    int n, nb, ne, t, ncyc;

    ir_drive_ctrl #(
        .HOLD_CYC   (HOLD),
        .DEAD_CYC   (DEAD),
        .PWM_PERIOD (PER),
        .PWM_STEP   (STEP),
        .SPEED_INIT (SINIT)
    ) dut (
        .clk_d      (clk_d),
        .rst        (rst),
        .key_onehot (key_onehot),
        .mot_l_en   (mot_l_en),
        .mot_l_dir  (mot_l_dir),
        .mot_r_en   (mot_r_en),
        .mot_r_dir  (mot_r_dir),
        .speed_lvl  (speed_lvl),
        .eff_lvl    (eff_lvl),
        .drv_state  (drv_state)
    );

    always #5 clk_d = ~clk_d;

    // Model: states as ints, timeouts as absolute cycle deadlines
    int          m_st, m_pend, m_spd, m_now, m_hold_dl, m_dead_dl;
    logic [16:0] m_prev;
    logic [14:0] exp_v;

    function automatic int key_target(logic [16:0] k);
        if (k == K_UP)   return 1;
        if (k == K_DOWN) return 2;
        if (k == K_LEFT) return 3;
        if (k == 17'h00004) return 4;
        return 0;
    endfunction

    function automatic logic [1:0] dirs_of(int s);
        if (s == 1) return 2'b11;
        if (s == 3) return 2'b01;
        if (s == 4) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_step(input logic [16:0] k, input logic r);
        bit ev, mot, en;
        int tgt, eff;
        logic [1:0] d;
        if (r) begin
            m_st = 0; m_pend = 0; m_spd = SINIT; m_now = 0; m_prev = '0;
            exp_v = {3'd0, 4'(SINIT), 4'd0, 4'd0};
            return;
        end
        mot = (m_st >= 1 && m_st <= 4);
        eff = mot ? m_spd : 0;
        en  = mot && ((m_now % PER) < eff * STEP);
        d   = dirs_of(m_st);
        exp_v = {3'(m_st), 4'(m_spd), 4'(eff), en, d[1], en, d[0]};
        ev  = (k != 0) && ($countones(k) == 1) && (m_prev == 0);
        tgt = ev ? key_target(k) : 0;
        if (ev && k == K_OK) begin
            m_st = 0; m_pend = 0;
        end else if (m_st == 0) begin
            if (tgt != 0) begin m_st = tgt; m_hold_dl = m_now + HOLD; end
        end else if (m_st == 5) begin
            if (tgt != 0) m_pend = tgt;
            if (m_now == m_dead_dl) begin m_st = m_pend; m_hold_dl = m_now + HOLD; end
        end else if (tgt == m_st) begin
            m_hold_dl = m_now + HOLD;
        end else if (tgt != 0) begin
            m_pend = tgt; m_st = 5; m_dead_dl = m_now + DEAD;
        end else if (m_now == m_hold_dl) begin
            m_st = 0;
        end
        if (ev) begin
            for (int dg = 0; dg < 10; dg++)
                if (k == (17'd1 << (16 - dg))) m_spd = dg;
            if (k == K_STAR && m_spd > 0) m_spd = m_spd - 1;
            if (k == K_HASH && m_spd < 9) m_spd = m_spd + 1;
        end
        m_prev = k;
        m_now = m_now + 1;
    endtask

    task automatic cyc(input logic [16:0] k, input logic r);
        @(negedge clk_d);
        key_onehot = k;
        rst = r;
        @(posedge clk_d);
        model_step(k, r);
        #1;
        checks++;
        if ({drv_state, speed_lvl, eff_lvl, mot_l_en, mot_l_dir, mot_r_en, mot_r_dir} !== exp_v) begin
            failures++;
            $display("FAIL model t=%0t got=%h exp=%h", $time,
                     {drv_state, speed_lvl, eff_lvl, mot_l_en, mot_l_dir, mot_r_en, mot_r_dir}, exp_v);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [16:0] k, input int on, input int off);
        for (int i = 0; i < on; i++) cyc(k, 1'b0);
        for (int i = 0; i < off; i++) cyc('0, 1'b0);
    endtask

    typedef struct {
        logic [16:0] key;
        int spd;
        int st;
        int en;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{K_HASH, 6, 0, -1};
        tbl[1]  = '{K_HASH, 7, 0, -1};
        tbl[2]  = '{K_HASH, 8, 0, -1};
        tbl[3]  = '{K_HASH, 9, 0, -1};
        tbl[4]  = '{K_HASH, 9, 0, -1};
        tbl[5]  = '{K_HASH, 9, 0, -1};
        tbl[6]  = '{K_0, 0, 0, -1};
        tbl[7]  = '{K_UP, 0, 1, 0};
        tbl[8]  = '{K_7, 7, 1, -1};
        tbl[9]  = '{K_STAR, 6, 1, -1};
        tbl[10] = '{K_STAR | K_HASH, 6, 1, -1};
        tbl[11] = '{K_OK, 6, 0, -1};
        tbl[12] = '{K_1, 1, 0, -1};
        tbl[13] = '{K_STAR, 0, 0, -1};
        tbl[14] = '{K_STAR, 0, 0, -1};
        tbl[15] = '{K_9, 9, 0, -1};

        cyc('0, 1'b1);
        cyc('0, 1'b1);
        chk("reset_drv", int'(drv_state), 0);
        chk("reset_spd", int'(speed_lvl), SINIT);
        chk("reset_out", int'({eff_lvl, mot_l_en, mot_l_dir, mot_r_en, mot_r_dir}), 0);

        // Forward latency, duty and hold expiry
        cyc(K_UP, 1'b0);
        chk("fwd_lat1", int'(drv_state), 0);
        cyc(K_UP, 1'b0);
        chk("fwd_lat2", int'(drv_state), 1);
        cyc(K_UP, 1'b0);
        cyc(K_UP, 1'b0);
        chk("fwd_dirs", int'({mot_l_dir, mot_r_dir}), 3);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc('0, 1'b0);
            n += int'(mot_l_en);
        end
        chk("fwd_duty", n, 5);
        t = 14;
        while (drv_state != 3'd0 && t < 300) begin
            cyc('0, 1'b0);
            t++;
        end
        chk("hold_expiry", t, 102);

        // FWD -> BRAKE -> REV
        pulse(K_UP, 2, 4);
        nb = 0; ne = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(i < 2 ? K_DOWN : 17'd0, 1'b0);
            if (drv_state == 3'd5) begin
                nb++;
                if (mot_l_en || mot_r_en) ne++;
            end
        end
        chk("brake_len", nb, 10);
        chk("brake_en", ne, 0);
        chk("rev_state", int'(drv_state), 2);
        chk("rev_dirs", int'({mot_l_dir, mot_r_dir}), 0);

        // New target mid-brake keeps the original dead-time
        nb = 0;
        for (int i = 0; i < 32; i++) begin
            cyc((i < 2) ? K_UP : ((i == 4 || i == 5) ? K_LEFT : 17'd0), 1'b0);
            if (drv_state == 3'd5) nb++;
        end
        chk("brake_repend_len", nb, 10);
        chk("turnl_state", int'(drv_state), 3);
        chk("turnl_dirs", int'({mot_l_dir, mot_r_dir}), 1);
        pulse(K_OK, 2, 3);
        chk("ok_stop", int'(drv_state), 0);

        for (int i = 0; i < 16; i++) begin
            n = 0;
            for (int j = 0; j < 6; j++) begin
                cyc(j < 3 ? tbl[i].key : 17'd0, 1'b0);
                n += int'(mot_l_en | mot_r_en);
            end
            chk($sformatf("vec%0d_spd", i), int'(speed_lvl), tbl[i].spd);
            chk($sformatf("vec%0d_st", i), int'(drv_state), tbl[i].st);
            if (tbl[i].en >= 0) chk($sformatf("vec%0d_en", i), n, tbl[i].en);
        end

        // Continuously held key yields one event
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(K_UP, 1'b0);
            if (drv_state == 3'd1) n++;
        end
        chk("held_once", n, 100);
        chk("held_stop", int'(drv_state), 0);
        pulse('0, 0, 2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(K_UP | K_DOWN, 1'b0);
            if (drv_state != 3'd0) n++;
        end
        chk("multi_ignored", n, 0);
        pulse('0, 0, 2);

        // Key event in the hold-expiry cycle reloads
        for (int i = 1; i <= 103; i++) begin
            cyc((i <= 3 || i == 101) ? K_UP : 17'd0, 1'b0);
            if (i == 103) chk("expiry_key_wins", int'(drv_state), 1);
        end

        // Reset while braking
        pulse(K_7, 2, 3);
        pulse(K_DOWN, 2, 3);
        chk("pre_rst_brake", int'(drv_state), 5);
        cyc('0, 1'b1);
        chk("rst_drv", int'(drv_state), 0);
        chk("rst_spd", int'(speed_lvl), SINIT);
        chk("rst_out", int'({eff_lvl, mot_l_en, mot_l_dir, mot_r_en, mot_r_dir}), 0);
        cyc('0, 1'b0);

        ncyc = 0;
        while (ncyc < 6000) begin
            logic [16:0] k;
            logic r;
            int sel, dur;
            sel = $urandom_range(0, 99);
            r = 1'b0;
            k = '0;
            if (sel < 45) begin
                dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 120) : $urandom_range(1, 5);
            end else if (sel < 88) begin
                k = 17'd1 << (($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : $urandom_range(0, 16));
                dur = $urandom_range(1, 6);
            end else if (sel < 98) begin
                k = 17'($urandom);
                dur = $urandom_range(1, 4);
            end else begin
                r = 1'b1;
                dur = $urandom_range(1, 2);
            end
            for (int i = 0; i < dur; i++) cyc(k, r);
            ncyc += dur;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
